ascon_block_sequencer: RTL and testbench

- Sequential successor of the combinational size decoder for the Ascon-AEAD128 datapath.
- Latches the associated-data (AD) and data-in (DI) byte counts on start.
- Emits one block descriptor per rate block over a valid/ready handshake: phase, block index, valid byte count, pad index and last flag.
- Sits between the register front-end and the permutation/absorb controller; padding blocks are generated explicitly, so the controller never derives block counts itself.

---
 rtl/ascon_block_sequencer.sv | 157 +++++++++++++++
 tb/tb_ascon_block_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_block_sequencer.sv
// Ascon-AEAD128 block sequencer: turns latched AD/DI byte counts into one
// descriptor per rate block (phase, index, byte count, pad index, last).
// Optional macro ASCON_SEQ_BYTE_MASK_EN adds a per-byte valid mask output.
module ascon_block_sequencer #(
  parameter int unsigned SIZE_WIDTH = 16,
  parameter int unsigned RATE_BYTES = 16,
  localparam int unsigned PAD_AW   = $clog2(RATE_BYTES),
  localparam int unsigned BLOCK_AW = SIZE_WIDTH - PAD_AW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [SIZE_WIDTH-1:0] ad_size_i,
  input  logic [SIZE_WIDTH-1:0] di_size_i,
  output logic                  busy_o,
  output logic                  blk_valid_o,
  input  logic                  blk_ready_i,
  output logic                  blk_phase_o,
  output logic [BLOCK_AW:0]     blk_idx_o,
  output logic [PAD_AW:0]       blk_bytes_o,
  output logic [PAD_AW-1:0]     blk_pad_idx_o,
  output logic                  blk_last_o,
  output logic                  done_o
`ifdef ASCON_SEQ_BYTE_MASK_EN
  ,
  output logic [RATE_BYTES-1:0] blk_mask_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AD   = 2'd1,
    ST_DI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [SIZE_WIDTH-1:0] ad_size_q, ad_size_d;
  logic [SIZE_WIDTH-1:0] di_size_q, di_size_d;
  logic [BLOCK_AW:0]     idx_d;

  logic                  busy_d;
  logic                  valid_d;
  logic                  phase_d;
  logic [BLOCK_AW:0]     blk_idx_d;
  logic [PAD_AW:0]       bytes_d;
  logic [PAD_AW-1:0]     pad_idx_d;
  logic                  last_d;
  logic                  done_d;

  logic [SIZE_WIDTH-1:0] cur_size;
  logic [BLOCK_AW-1:0]   full_blks;
  logic [PAD_AW-1:0]     tail_bytes;

  // Next state, then the descriptor for the block the next state will present
  always_comb begin
    state_d   = state_q;
    ad_size_d = ad_size_q;
    di_size_d = di_size_q;
    idx_d     = blk_idx_o;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          ad_size_d = ad_size_i;
          di_size_d = di_size_i;
          idx_d     = '0;
          state_d   = (ad_size_i != '0) ? ST_AD : ST_DI;
        end
      end
      ST_AD, ST_DI: begin
        if (blk_valid_o && blk_ready_i) begin
          if (!blk_last_o) begin
            idx_d = blk_idx_o + (BLOCK_AW+1)'(1);
          end else if (state_q == ST_AD) begin
            idx_d   = '0;
            state_d = ST_DI;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cur_size   = (state_d == ST_DI) ? di_size_d : ad_size_d;
    full_blks  = cur_size[SIZE_WIDTH-1:PAD_AW];
    tail_bytes = cur_size[PAD_AW-1:0];

    valid_d   = (state_d == ST_AD) || (state_d == ST_DI);
    phase_d   = (state_d == ST_DI);
    blk_idx_d = valid_d ? idx_d : '0;
    last_d    = valid_d && (idx_d == {1'b0, full_blks});
    bytes_d   = '0;
    pad_idx_d = '0;
    if (last_d) begin
      bytes_d   = {1'b0, tail_bytes};
      pad_idx_d = tail_bytes;
    end else if (valid_d) begin
      bytes_d   = (PAD_AW+1)'(RATE_BYTES);
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
  end

`ifdef ASCON_SEQ_BYTE_MASK_EN
  logic [RATE_BYTES-1:0] mask_d;

  // Byte i is live when it lies below the block's byte count
  always_comb begin
    mask_d = '0;
    for (int unsigned i = 0; i < RATE_BYTES; i++) begin
      mask_d[i] = ((PAD_AW+1)'(i) < bytes_d);
    end
  end

  // Mask register tracks the descriptor registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blk_mask_o <= '0;
    end else begin
      blk_mask_o <= mask_d;
    end
  end
`endif

  // State, latched sizes and registered descriptor outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      ad_size_q     <= '0;
      di_size_q     <= '0;
      busy_o        <= 1'b0;
      blk_valid_o   <= 1'b0;
      blk_phase_o   <= 1'b0;
      blk_idx_o     <= '0;
      blk_bytes_o   <= '0;
      blk_pad_idx_o <= '0;
      blk_last_o    <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ad_size_q     <= ad_size_d;
      di_size_q     <= di_size_d;
      busy_o        <= busy_d;
      blk_valid_o   <= valid_d;
      blk_phase_o   <= phase_d;
      blk_idx_o     <= blk_idx_d;
      blk_bytes_o   <= bytes_d;
      blk_pad_idx_o <= pad_idx_d;
      blk_last_o    <= last_d;
      done_o        <= done_d;
    end
  end

endmodule

// File: tb/tb_ascon_block_sequencer.sv
// Directed testbench for ascon_block_sequencer (SIZE_WIDTH=16, RATE_BYTES=16).
// Define ASCON_SEQ_BYTE_MASK_EN to also check blk_mask_o.
module tb_ascon_block_sequencer;

  localparam int unsigned SIZE_WIDTH = 16;
  localparam int unsigned RATE_BYTES = 16;
  localparam int unsigned PAD_AW     = 4;
  localparam int unsigned BLOCK_AW   = 12;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  start_i;
  logic [SIZE_WIDTH-1:0] ad_size_i;
  logic [SIZE_WIDTH-1:0] di_size_i;
  logic                  busy_o;
  logic                  blk_valid_o;
  logic                  blk_ready_i;
  logic                  blk_phase_o;
  logic [BLOCK_AW:0]     blk_idx_o;
  logic [PAD_AW:0]       blk_bytes_o;
  logic [PAD_AW-1:0]     blk_pad_idx_o;
  logic                  blk_last_o;
  logic                  done_o;
`ifdef ASCON_SEQ_BYTE_MASK_EN
  logic [RATE_BYTES-1:0] blk_mask_o;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  ascon_block_sequencer #(
    .SIZE_WIDTH (SIZE_WIDTH),
    .RATE_BYTES (RATE_BYTES)
  ) u_dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .ad_size_i     (ad_size_i),
    .di_size_i     (di_size_i),
    .busy_o        (busy_o),
    .blk_valid_o   (blk_valid_o),
    .blk_ready_i   (blk_ready_i),
    .blk_phase_o   (blk_phase_o),
    .blk_idx_o     (blk_idx_o),
    .blk_bytes_o   (blk_bytes_o),
    .blk_pad_idx_o (blk_pad_idx_o),
    .blk_last_o    (blk_last_o),
    .done_o        (done_o)
`ifdef ASCON_SEQ_BYTE_MASK_EN
    ,
    .blk_mask_o    (blk_mask_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Single comparison point: counts and reports mismatches
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_blk(input string tag, input logic phase, input int idx,
                            input int bytes, input int pad, input logic last);
    check_eq({tag, ".valid"}, 32'(blk_valid_o), 32'd1);
    check_eq({tag, ".phase"}, 32'(blk_phase_o), 32'(phase));
    check_eq({tag, ".idx"},   32'(blk_idx_o),   32'(idx));
    check_eq({tag, ".bytes"}, 32'(blk_bytes_o), 32'(bytes));
    check_eq({tag, ".pad"},   32'(blk_pad_idx_o), 32'(pad));
    check_eq({tag, ".last"},  32'(blk_last_o),  32'(last));
    check_eq({tag, ".busy"},  32'(busy_o),      32'd1);
`ifdef ASCON_SEQ_BYTE_MASK_EN
    begin
      logic [31:0] exp_mask;
      exp_mask = (bytes >= 16) ? 32'h0000_FFFF : ((32'd1 << bytes) - 32'd1);
      check_eq({tag, ".mask"}, 32'(blk_mask_o), exp_mask);
    end
`endif
  endtask

  task automatic expect_idle_gap(input string tag);
    check_eq({tag, ".valid"}, 32'(blk_valid_o), 32'd0);
    check_eq({tag, ".done"},  32'(done_o),      32'd0);
  endtask

  task automatic expect_done(input string tag);
    check_eq({tag, ".done"},  32'(done_o),      32'd1);
    check_eq({tag, ".busy"},  32'(busy_o),      32'd0);
    check_eq({tag, ".valid"}, 32'(blk_valid_o), 32'd0);
    step();
    check_eq({tag, ".done_end"}, 32'(done_o), 32'd0);
  endtask

  task automatic do_start(input int ad, input int di);
    ad_size_i = 16'(ad);
    di_size_i = 16'(di);
    start_i   = 1'b1;
    step();
    start_i   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i       = 1'b1;
    start_i     = 1'b0;
    ad_size_i   = '0;
    di_size_i   = '0;
    blk_ready_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    check_eq("rst.busy",  32'(busy_o),      32'd0);
    check_eq("rst.valid", 32'(blk_valid_o), 32'd0);
    check_eq("rst.done",  32'(done_o),      32'd0);
    check_eq("rst.idx",   32'(blk_idx_o),   32'd0);
    check_eq("rst.bytes", 32'(blk_bytes_o), 32'd0);
    step();

    // ad=0 di=0: one pad-only DI block, done two edges after handshake
    do_start(0, 0);
    expect_blk("t1.di0", 1'b1, 0, 0, 0, 1'b1);
    step();
    expect_idle_gap("t1.gap");
    check_eq("t1.gap.busy", 32'(busy_o), 32'd1);
    step();
    expect_done("t1");

    // ad=20 di=5: AD {16, 4-last}, DI {5-last}, back to back
    do_start(20, 5);
    expect_blk("t2.ad0", 1'b0, 0, 16, 0, 1'b0);
    step();
    expect_blk("t2.ad1", 1'b0, 1, 4, 4, 1'b1);
    step();
    expect_blk("t2.di0", 1'b1, 0, 5, 5, 1'b1);
    step();
    expect_idle_gap("t2.gap");
    step();
    expect_done("t2");

    // ad=16 di=32: trailing pad-only block in each phase
    do_start(16, 32);
    expect_blk("t3.ad0", 1'b0, 0, 16, 0, 1'b0);
    step();
    expect_blk("t3.ad1", 1'b0, 1, 0, 0, 1'b1);
    step();
    expect_blk("t3.di0", 1'b1, 0, 16, 0, 1'b0);
    step();
    expect_blk("t3.di1", 1'b1, 1, 16, 0, 1'b0);
    step();
    expect_blk("t3.di2", 1'b1, 2, 0, 0, 1'b1);
    step();
    expect_idle_gap("t3.gap");
    step();
    expect_done("t3");

    // Backpressure: ready alternates 0/1, descriptors must hold while 0
    blk_ready_i = 1'b0;
    do_start(40, 0);
    expect_blk("t4.ad0", 1'b0, 0, 16, 0, 1'b0);
    step();
    expect_blk("t4.ad0h", 1'b0, 0, 16, 0, 1'b0);
    blk_ready_i = 1'b1;
    step();
    blk_ready_i = 1'b0;
    expect_blk("t4.ad1", 1'b0, 1, 16, 0, 1'b0);
    step();
    expect_blk("t4.ad1h", 1'b0, 1, 16, 0, 1'b0);
    blk_ready_i = 1'b1;
    step();
    blk_ready_i = 1'b0;
    expect_blk("t4.ad2", 1'b0, 2, 8, 8, 1'b1);
    step();
    expect_blk("t4.ad2h", 1'b0, 2, 8, 8, 1'b1);
    blk_ready_i = 1'b1;
    step();
    blk_ready_i = 1'b0;
    expect_blk("t4.di0", 1'b1, 0, 0, 0, 1'b1);
    step();
    expect_blk("t4.di0h", 1'b1, 0, 0, 0, 1'b1);
    blk_ready_i = 1'b1;
    step();
    expect_idle_gap("t4.gap");
    step();
    expect_done("t4");

    // Restart ignored while busy, then reset abandons the sequence
    blk_ready_i = 1'b0;
    do_start(0, 40);
    expect_blk("t5.di0", 1'b1, 0, 16, 0, 1'b0);
    do_start(5, 1);
    expect_blk("t5.di0h", 1'b1, 0, 16, 0, 1'b0);
    blk_ready_i = 1'b1;
    step();
    blk_ready_i = 1'b0;
    expect_blk("t5.di1", 1'b1, 1, 16, 0, 1'b0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check_eq("t5.rst.busy",  32'(busy_o),      32'd0);
    check_eq("t5.rst.valid", 32'(blk_valid_o), 32'd0);
    check_eq("t5.rst.done",  32'(done_o),      32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t5.nodone", 32'(done_o), 32'd0);
      check_eq("t5.novalid", 32'(blk_valid_o), 32'd0);
    end
    blk_ready_i = 1'b1;
    do_start(0, 17);
    expect_blk("t5.di0b", 1'b1, 0, 16, 0, 1'b0);
    step();
    expect_blk("t5.di1b", 1'b1, 1, 1, 1, 1'b1);
    step();
    expect_idle_gap("t5.gap");
    step();
    expect_done("t5");

`ifdef ASCON_SEQ_BYTE_MASK_EN
    // Explicit mask constants: full, pad-only and 3-byte blocks
    do_start(16, 3);
    check_eq("t6.mask_full", 32'(blk_mask_o), 32'h0000_FFFF);
    step();
    check_eq("t6.mask_pad",  32'(blk_mask_o), 32'h0000_0000);
    step();
    check_eq("t6.mask_di3",  32'(blk_mask_o), 32'h0000_0007);
    step();
    step();
    expect_done("t6");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
